// File: rtl/la_ioring_seq.sv
// la_ioring_seq: core-side power sequencer for the generic io-ring control bus.
// Power-up order: pads held safe -> POC released -> inputs on -> outputs on.
// Power-down runs in reverse. Loss of the IO supply forces the safe state at once.
// Optional build macro LA_IORING_RETENTION_EN adds a 'sleep' input and a
// retention state that holds the pads with ret=1.
module la_ioring_seq #(
    parameter     TYPE  = "DEFAULT",
    parameter int RINGW = 8,
    parameter int DLYW  = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             vddio_ok,
    input  logic             start,
    input  logic             stop,
`ifdef LA_IORING_RETENTION_EN
    input  logic             sleep,
`endif
    input  logic [DLYW-1:0]  dly,
    output logic [RINGW-1:0] ioring,
    output logic             ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_OFF, S_WAITIO, S_RELEASE, S_INEN, S_ACTIVE, S_OEOFF, S_IEOFF, S_RETAIN
    } state_t;

    localparam logic [DLYW-1:0] CNT_ONE = {{(DLYW-1){1'b0}}, 1'b1};

    logic            r_vok_meta;
    logic            r_vok;
    state_t          r_state;
    logic [DLYW-1:0] r_cnt;
    logic [2:0]      r_ctl;     // {oe, ie, poc}
    logic            r_ready;
    logic            r_busy;
    logic            w_ret;

    state_t          w_state_next;
    logic [DLYW-1:0] w_cnt_next;
    logic            w_timeout;
    logic [4:0]      w_dec_next; // {busy, ready, oe, ie, poc}

    // Steps that wait dly+1 cycles before advancing.
    function automatic logic is_timed(input state_t s);
        return (s == S_WAITIO) || (s == S_RELEASE) || (s == S_INEN) ||
               (s == S_OEOFF)  || (s == S_IEOFF);
    endfunction

    // Output encoding per state as {busy, ready, oe, ie, poc}.
    function automatic logic [4:0] decode(input state_t s);
        case (s)
            S_OFF:     return 5'b00_001;
            S_WAITIO:  return 5'b10_001;
            S_RELEASE: return 5'b10_000;
            S_INEN:    return 5'b10_010;
            S_ACTIVE:  return 5'b01_110;
            S_OEOFF:   return 5'b10_010;
            S_IEOFF:   return 5'b10_000;
            S_RETAIN:  return 5'b10_110;
            default:   return 5'b00_001;
        endcase
    endfunction

    assign w_timeout = (r_cnt == '0);

    // Next-state selection; supply loss overrides every other condition.
    always_comb begin
        w_state_next = r_state;
        if ((r_state != S_OFF) && !r_vok) begin
            w_state_next = S_OFF;
        end else begin
            case (r_state)
                S_OFF:     if (start && r_vok) w_state_next = S_WAITIO;
                S_WAITIO:  if (w_timeout)      w_state_next = S_RELEASE;
                S_RELEASE: if (w_timeout)      w_state_next = S_INEN;
                S_INEN:    if (w_timeout)      w_state_next = S_ACTIVE;
                S_ACTIVE: begin
                    if (stop)                  w_state_next = S_OEOFF;
`ifdef LA_IORING_RETENTION_EN
                    else if (sleep)            w_state_next = S_RETAIN;
`endif
                end
                S_OEOFF:   if (w_timeout)      w_state_next = S_IEOFF;
                S_IEOFF:   if (w_timeout)      w_state_next = S_OFF;
`ifdef LA_IORING_RETENTION_EN
                S_RETAIN:  if (!sleep)         w_state_next = S_ACTIVE;
`endif
                default:                       w_state_next = S_OFF;
            endcase
        end
    end

    // Step counter: load dly on entry to a timed step, count down while in it.
    always_comb begin
        w_cnt_next = '0;
        if (w_state_next != r_state) begin
            if (is_timed(w_state_next)) w_cnt_next = dly;
        end else if (is_timed(r_state)) begin
            w_cnt_next = r_cnt - CNT_ONE;
        end
    end

    assign w_dec_next = decode(w_state_next);

    // Supply synchronizer, state, counter and outputs registered from the next state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_vok_meta <= 1'b0;
            r_vok      <= 1'b0;
            r_state    <= S_OFF;
            r_cnt      <= '0;
            r_ctl      <= 3'b001;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_vok_meta <= vddio_ok;
            r_vok      <= r_vok_meta;
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_ctl      <= w_dec_next[2:0];
            r_ready    <= w_dec_next[3];
            r_busy     <= w_dec_next[4];
        end
    end

`ifdef LA_IORING_RETENTION_EN
    logic r_ret;

    // Retention flag is raised only while the next state is RETAIN.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_ret <= 1'b0;
        else         r_ret <= (w_state_next == S_RETAIN);
    end

    assign w_ret = r_ret;
`else
    assign w_ret = 1'b0;
`endif

    assign ready = r_ready;
    assign busy  = r_busy;

    // Ring bus assembly; technology variants would replace the non-default branch.
    generate
        if (TYPE == "DEFAULT") begin : g_generic
            for (genvar gi = 0; gi < RINGW; gi++) begin : g_bit
                if (gi < 3) begin : g_ctl
                    assign ioring[gi] = r_ctl[gi];
                end else if (gi == 3) begin : g_ret
                    assign ioring[gi] = w_ret;
                end else begin : g_zero
                    assign ioring[gi] = 1'b0;
                end
            end
        end else begin : g_tech
            for (genvar gi = 0; gi < RINGW; gi++) begin : g_bit
                if (gi < 3) begin : g_ctl
                    assign ioring[gi] = r_ctl[gi];
                end else if (gi == 3) begin : g_ret
                    assign ioring[gi] = w_ret;
                end else begin : g_zero
                    assign ioring[gi] = 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_la_ioring_seq.sv
// Self-checking bench for la_ioring_seq: expected per-cycle outputs are queued
// when stimulus is applied and compared one cycle at a time after each edge.
module tb_la_ioring_seq;
    localparam int RINGW = 8;
    localparam int DLYW  = 8;

    logic             clk = 1'b0;
    logic             nreset;
    logic             vddio_ok;
    logic             start;
    logic             stop;
    logic [DLYW-1:0]  dly;
    logic [RINGW-1:0] ioring;
    logic             ready;
    logic             busy;
`ifdef LA_IORING_RETENTION_EN
    logic             sleep;
`endif

    always #5 clk = ~clk;

    la_ioring_seq #(.TYPE("DEFAULT"), .RINGW(RINGW), .DLYW(DLYW)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .vddio_ok (vddio_ok),
        .start    (start),
        .stop     (stop),
`ifdef LA_IORING_RETENTION_EN
        .sleep    (sleep),
`endif
        .dly      (dly),
        .ioring   (ioring),
        .ready    (ready),
        .busy     (busy)
    );

    typedef struct {
        logic [RINGW-1:0] ring;
        logic             rdy;
        logic             bsy;
    } exp_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_mis = 0;
    int    n_cyc = 0;
    string phase = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s.%s: observed %0h expected %0h (cycle %0d)", phase, tag, obs, exp, n_cyc);
        end
    endtask

    task automatic expect_n(input int n, input logic [RINGW-1:0] ring, input logic rdy, input logic bsy);
        exp_t e;
        e.ring = ring;
        e.rdy  = rdy;
        e.bsy  = bsy;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            n_cyc++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL %s.sb_underrun: observed empty queue expected an entry (cycle %0d)", phase, n_cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ioring", {24'd0, ioring}, {24'd0, e.ring});
                chk("ready", {31'd0, ready}, {31'd0, e.rdy});
                chk("busy", {31'd0, busy}, {31'd0, e.bsy});
                $display("cyc %0d %s ioring=%02h ready=%b busy=%b", n_cyc, phase, ioring, ready, busy);
            end
        end
    endtask

    initial begin
        nreset   = 1'b0;
        vddio_ok = 1'b1;
        start    = 1'b1;
        stop     = 1'b0;
        dly      = 8'd3;
`ifdef LA_IORING_RETENTION_EN
        sleep    = 1'b0;
`endif

        // Reset held with supply good and start requested: safe state throughout.
        phase = "reset";
        expect_n(4, 8'h01, 1'b0, 1'b0);
        run(4);

        // Power-up with dly=3; vok needs two edges, WAITIO entered on the third.
        nreset = 1'b1;
        phase  = "pwrup3";
        expect_n(2, 8'h01, 1'b0, 1'b0);
        expect_n(4, 8'h01, 1'b0, 1'b1);
        expect_n(4, 8'h00, 1'b0, 1'b1);
        expect_n(4, 8'h02, 1'b0, 1'b1);
        expect_n(1, 8'h06, 1'b1, 1'b0);
        run(3);
        start = 1'b0;
        stop  = 1'b1;   // stop during WAITIO must be ignored
        run(2);
        stop  = 1'b0;
        run(10);

        phase = "active";
        expect_n(3, 8'h06, 1'b1, 1'b0);
        run(3);

        // Orderly power-down, one cycle per step.
        phase = "pwrdn0";
        dly   = 8'd0;
        stop  = 1'b1;
        expect_n(1, 8'h02, 1'b0, 1'b1);
        expect_n(1, 8'h00, 1'b0, 1'b1);
        expect_n(3, 8'h01, 1'b0, 1'b0);
        run(1);
        stop = 1'b0;
        run(4);

        // Power-up with dly=0: one cycle per step.
        phase = "pwrup0";
        start = 1'b1;
        expect_n(1, 8'h01, 1'b0, 1'b1);
        expect_n(1, 8'h00, 1'b0, 1'b1);
        expect_n(1, 8'h02, 1'b0, 1'b1);
        expect_n(1, 8'h06, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        run(3);

`ifdef LA_IORING_RETENTION_EN
        phase = "retain";
        sleep = 1'b1;
        expect_n(1, 8'h0E, 1'b0, 1'b1);
        run(1);
        stop = 1'b1;    // ignored in RETAIN
        expect_n(1, 8'h0E, 1'b0, 1'b1);
        run(1);
        stop  = 1'b0;
        sleep = 1'b0;
        expect_n(1, 8'h06, 1'b1, 1'b0);
        run(1);
        sleep = 1'b1;
        expect_n(1, 8'h0E, 1'b0, 1'b1);
        run(1);
        vddio_ok = 1'b0;
        expect_n(2, 8'h0E, 1'b0, 1'b1);
        expect_n(1, 8'h01, 1'b0, 1'b0);
        run(3);
        vddio_ok = 1'b1;
        sleep    = 1'b0;
        expect_n(3, 8'h01, 1'b0, 1'b0);
        run(3);
`else
        phase = "pwrdn0b";
        stop  = 1'b1;
        expect_n(1, 8'h02, 1'b0, 1'b1);
        expect_n(1, 8'h00, 1'b0, 1'b1);
        expect_n(3, 8'h01, 1'b0, 1'b0);
        run(1);
        stop = 1'b0;
        run(4);
`endif

        // Supply drop in INEN mid-count: OFF exactly three edges later, never 06.
        phase = "vokloss";
        dly   = 8'd5;
        start = 1'b1;
        expect_n(6, 8'h01, 1'b0, 1'b1);
        expect_n(6, 8'h00, 1'b0, 1'b1);
        expect_n(2, 8'h02, 1'b0, 1'b1);
        run(1);
        start = 1'b0;
        run(13);
        vddio_ok = 1'b0;
        expect_n(2, 8'h02, 1'b0, 1'b1);
        expect_n(1, 8'h01, 1'b0, 1'b0);
        run(3);

        // Start without a good supply does nothing.
        phase = "novok";
        start = 1'b1;
        expect_n(2, 8'h01, 1'b0, 1'b0);
        run(2);

        // Supply returns with start held and dly=255: each step lasts 256 cycles.
        phase    = "pwrup255";
        dly      = 8'd255;
        vddio_ok = 1'b1;
        expect_n(2, 8'h01, 1'b0, 1'b0);
        expect_n(256, 8'h01, 1'b0, 1'b1);
        expect_n(256, 8'h00, 1'b0, 1'b1);
        expect_n(256, 8'h02, 1'b0, 1'b1);
        expect_n(1, 8'h06, 1'b1, 1'b0);
        run(3);
        start = 1'b0;
        run(768);

        // start and stop both held: full power-down, then restart from OFF.
        phase = "startstop";
        dly   = 8'd1;
        start = 1'b1;
        stop  = 1'b1;
        expect_n(2, 8'h02, 1'b0, 1'b1);
        expect_n(2, 8'h00, 1'b0, 1'b1);
        expect_n(1, 8'h01, 1'b0, 1'b0);
        expect_n(1, 8'h01, 1'b0, 1'b1);
        run(6);
        start = 1'b0;
        stop  = 1'b0;

        phase = "drain";
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: observed %0d leftover entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
